jtag_tap_target: RTL

- Target-side (device) end of the JTAG protocol: the responder the AVIP controller drives.
- Receives TMS/TDI on the TCK domain, runs the 16-state IEEE 1149.1 TAP machine using the package state encoding, and shifts data in and out of three registers:
  - instruction register;
  - bypass register;
  - user-defined register and boundary-scan register, each with capture inputs and update outputs.
- Drives TDO back to the controller. Serves as the DUT/reference responder in the AVIP environment.

---
 rtl/jtag_tap_target_if.sv | 32 +++
 rtl/jtag_tap_target.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_target_if.sv
// Signal bundle between a JTAG controller and the TAP target.
// TCK and the synchronous reset stay outside as plain ports.
interface jtag_tap_target_if #(
    parameter int unsigned INSTRUCTION_WIDTH = 5,
    parameter int unsigned USER_REG_WIDTH    = 32,
    parameter int unsigned BSR_WIDTH         = 32
);
    logic                         jtagTms;
    logic                         jtagTdi;
    logic                         jtagTdo;
    logic                         jtagTdoEnable;
    logic [3:0]                   jtagState;
    logic [INSTRUCTION_WIDTH-1:0] jtagInstruction;
    logic [USER_REG_WIDTH-1:0]    userCaptureIn;
    logic [BSR_WIDTH-1:0]         bsrCaptureIn;
    logic [USER_REG_WIDTH-1:0]    userUpdateOut;
    logic [BSR_WIDTH-1:0]         bsrUpdateOut;
    logic                         updateDrPulse;
    logic                         updateIrPulse;

    modport master (
        output jtagTms, jtagTdi, userCaptureIn, bsrCaptureIn,
        input  jtagTdo, jtagTdoEnable, jtagState, jtagInstruction,
               userUpdateOut, bsrUpdateOut, updateDrPulse, updateIrPulse
    );

    modport slave (
        input  jtagTms, jtagTdi, userCaptureIn, bsrCaptureIn,
        output jtagTdo, jtagTdoEnable, jtagState, jtagInstruction,
               userUpdateOut, bsrUpdateOut, updateDrPulse, updateIrPulse
    );
endinterface

// File: rtl/jtag_tap_target.sv
// JTAG TAP target: 16-state TAP controller, instruction register, bypass,
// user data register and boundary-scan register, all clocked on TCK rise.
module jtag_tap_target #(
    parameter int unsigned INSTRUCTION_WIDTH = 5,
    parameter int unsigned USER_REG_WIDTH    = 32,
    parameter int unsigned BSR_WIDTH         = 32,
    parameter logic [4:0]  IR_CAPTURE_VALUE  = 5'b00001
) (
    input logic              jtagTck,
    input logic              jtagRstN,
    jtag_tap_target_if.slave bus
);
    localparam int unsigned IW = INSTRUCTION_WIDTH;

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,  S_IDLE       = 4'd1,
        S_DR_SCAN    = 4'd2,  S_IR_SCAN    = 4'd3,
        S_CAPTURE_IR = 4'd4,  S_SHIFT_IR   = 4'd5,
        S_EXIT1_IR   = 4'd6,  S_PAUSE_IR   = 4'd7,
        S_EXIT2_IR   = 4'd8,  S_UPDATE_IR  = 4'd9,
        S_CAPTURE_DR = 4'd10, S_SHIFT_DR   = 4'd11,
        S_EXIT1_DR   = 4'd12, S_PAUSE_DR   = 4'd13,
        S_EXIT2_DR   = 4'd14, S_UPDATE_DR  = 4'd15
    } tap_state_e;

    typedef enum logic [1:0] {SEL_BYPASS, SEL_USER, SEL_BSR} dr_sel_e;

    tap_state_e                state_q, state_d;
    logic [IW-1:0]             ir_shift_q, ir_shift_d;
    logic [IW-1:0]             instr_q, instr_d;
    logic                      byp_q, byp_d;
    logic [USER_REG_WIDTH-1:0] user_shift_q, user_shift_d, user_upd_q, user_upd_d;
    logic [BSR_WIDTH-1:0]      bsr_shift_q, bsr_shift_d, bsr_upd_q, bsr_upd_d;
    logic                      tdo_q, tdo_d, tdo_en_q, tdo_en_d;
    logic                      upd_dr_q, upd_dr_d, upd_ir_q, upd_ir_d;
    logic [4:0]                opcode;
    dr_sel_e                   dr_sel;
    logic                      tms, tdi;

    assign tms = bus.jtagTms;
    assign tdi = bus.jtagTdi;

    // TAP controller next state from current state and TMS
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:      state_d = tms ? S_RESET      : S_IDLE;
            S_IDLE:       state_d = tms ? S_DR_SCAN    : S_IDLE;
            S_DR_SCAN:    state_d = tms ? S_IR_SCAN    : S_CAPTURE_DR;
            S_IR_SCAN:    state_d = tms ? S_RESET      : S_CAPTURE_IR;
            S_CAPTURE_IR: state_d = tms ? S_EXIT1_IR   : S_SHIFT_IR;
            S_SHIFT_IR:   state_d = tms ? S_EXIT1_IR   : S_SHIFT_IR;
            S_EXIT1_IR:   state_d = tms ? S_UPDATE_IR  : S_PAUSE_IR;
            S_PAUSE_IR:   state_d = tms ? S_EXIT2_IR   : S_PAUSE_IR;
            S_EXIT2_IR:   state_d = tms ? S_UPDATE_IR  : S_SHIFT_IR;
            S_UPDATE_IR:  state_d = tms ? S_DR_SCAN    : S_IDLE;
            S_CAPTURE_DR: state_d = tms ? S_EXIT1_DR   : S_SHIFT_DR;
            S_SHIFT_DR:   state_d = tms ? S_EXIT1_DR   : S_SHIFT_DR;
            S_EXIT1_DR:   state_d = tms ? S_UPDATE_DR  : S_PAUSE_DR;
            S_PAUSE_DR:   state_d = tms ? S_EXIT2_DR   : S_PAUSE_DR;
            S_EXIT2_DR:   state_d = tms ? S_UPDATE_DR  : S_SHIFT_DR;
            S_UPDATE_DR:  state_d = tms ? S_DR_SCAN    : S_IDLE;
            default:      state_d = S_RESET;
        endcase
    end

    // Decode the active instruction (zero-extended to 5 bits) into a DR select;
    // the instruction is stable for the whole DR scan, so no latch is needed
    always_comb begin
        opcode         = '0;
        opcode[IW-1:0] = instr_q;
        case (opcode)
            5'b00001: dr_sel = SEL_USER;
            5'b00110: dr_sel = SEL_BSR;
            default:  dr_sel = SEL_BYPASS;
        endcase
    end

    // Capture / shift / update datapath and registered TDO
    always_comb begin
        ir_shift_d   = ir_shift_q;
        instr_d      = instr_q;
        byp_d        = byp_q;
        user_shift_d = user_shift_q;
        user_upd_d   = user_upd_q;
        bsr_shift_d  = bsr_shift_q;
        bsr_upd_d    = bsr_upd_q;
        upd_dr_d     = 1'b0;
        upd_ir_d     = 1'b0;
        tdo_d        = 1'b0;
        tdo_en_d     = 1'b0;

        case (state_q)
            S_CAPTURE_IR: ir_shift_d = IR_CAPTURE_VALUE[IW-1:0];
            S_SHIFT_IR:   ir_shift_d = {tdi, ir_shift_q[IW-1:1]};
            S_UPDATE_IR: begin
                instr_d  = ir_shift_q;
                upd_ir_d = 1'b1;
            end
            S_CAPTURE_DR: begin
                case (dr_sel)
                    SEL_USER: user_shift_d = bus.userCaptureIn;
                    SEL_BSR:  bsr_shift_d  = bus.bsrCaptureIn;
                    default:  byp_d        = 1'b0;
                endcase
            end
            S_SHIFT_DR: begin
                case (dr_sel)
                    SEL_USER: user_shift_d = {tdi, user_shift_q[USER_REG_WIDTH-1:1]};
                    SEL_BSR:  bsr_shift_d  = {tdi, bsr_shift_q[BSR_WIDTH-1:1]};
                    default:  byp_d        = tdi;
                endcase
            end
            S_UPDATE_DR: begin
                // bypass still pulses, but has no update stage
                upd_dr_d = 1'b1;
                case (dr_sel)
                    SEL_USER: user_upd_d = user_shift_q;
                    SEL_BSR:  bsr_upd_d  = bsr_shift_q;
                    default:  ;
                endcase
            end
            default: ;
        endcase

        // Reaching Test-Logic-Reset via TMS always falls back to bypass
        if (state_d == S_RESET) instr_d = '0;

        // TDO presents bit 0 of the post-edge shift stage while shifting
        if (state_d == S_SHIFT_IR) begin
            tdo_d    = ir_shift_d[0];
            tdo_en_d = 1'b1;
        end else if (state_d == S_SHIFT_DR) begin
            tdo_en_d = 1'b1;
            case (dr_sel)
                SEL_USER: tdo_d = user_shift_d[0];
                SEL_BSR:  tdo_d = bsr_shift_d[0];
                default:  tdo_d = byp_d;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge jtagTck) begin
        if (!jtagRstN) begin
            state_q      <= S_RESET;
            ir_shift_q   <= '0;
            instr_q      <= '0;
            byp_q        <= 1'b0;
            user_shift_q <= '0;
            user_upd_q   <= '0;
            bsr_shift_q  <= '0;
            bsr_upd_q    <= '0;
            tdo_q        <= 1'b0;
            tdo_en_q     <= 1'b0;
            upd_dr_q     <= 1'b0;
            upd_ir_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_shift_q   <= ir_shift_d;
            instr_q      <= instr_d;
            byp_q        <= byp_d;
            user_shift_q <= user_shift_d;
            user_upd_q   <= user_upd_d;
            bsr_shift_q  <= bsr_shift_d;
            bsr_upd_q    <= bsr_upd_d;
            tdo_q        <= tdo_d;
            tdo_en_q     <= tdo_en_d;
            upd_dr_q     <= upd_dr_d;
            upd_ir_q     <= upd_ir_d;
        end
    end

    assign bus.jtagTdo         = tdo_q;
    assign bus.jtagTdoEnable   = tdo_en_q;
    assign bus.jtagState       = state_q;
    assign bus.jtagInstruction = instr_q;
    assign bus.userUpdateOut   = user_upd_q;
    assign bus.bsrUpdateOut    = bsr_upd_q;
    assign bus.updateDrPulse   = upd_dr_q;
    assign bus.updateIrPulse   = upd_ir_q;
endmodule
